mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Load/store unit between the ALU (execute) and the 32-word data memory. Takes byte-addressed
//  LB/LH/LW/LBU/LHU/SB/SH/SW requests and converts them to word-indexed memory cycles.
//  Sub-word stores use read-modify-write. Sub-word loads are sign/zero extended.
//  Loaded data goes to the writeback mux.
// PARAMETERS
//  MEM_WORDS  32  words in the data memory; word index >= MEM_WORDS is an error
//  XLEN       32  data and address width
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     synchronous reset, active-low
//  req_valid  in   1     execute stage presents a request
//  req_ready  out  1     controller can accept (IDLE only)
//  req_store  in   1     1 = store, 0 = load
//  req_funct3 in   3     000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 stores
//  req_addr   in   XLEN  byte address (ALU result)
//  req_wdata  in   XLEN  store data (rs2 value)
//  mem_read   out  1     read strobe to data memory
//  mem_write  out  1     write strobe to data memory
//  mem_addr   out  XLEN  word index = addr[31:2]
//  mem_wdata  out  XLEN  full word to write
//  mem_rdata  in   XLEN  memory read data, registered: valid the cycle after mem_read
//  rsp_valid  out  1     result/completion for writeback
//  rsp_ready  in   1     writeback accepts
//  rsp_data   out  XLEN  extended load data; 0 for stores and errors
//  rsp_err    out  1     misaligned or out-of-range access
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; all outputs and latched request regs 0 except req_ready.
//    req_ready=1 after reset. Reset wins over every other event.
//    A reset mid-operation aborts the request; no mem_write is issued that cycle or later.
//  - Accept on req_valid & req_ready. Latch addr, wdata, funct3, store, all at once.
//  - Error check at accept: H with addr[0]!=0, W with addr[1:0]!=0, or addr[31:2]>=MEM_WORDS.
//    On error go to RESP with rsp_err=1 and rsp_data=0. No memory strobe is issued.
//  - FSM transitions:
//      IDLE -> WR   for SW
//      IDLE -> RD   for all loads and SB/SH
//      RD   -> WAIT
//      WAIT -> RESP for loads
//      WAIT -> WR   for SB/SH
//      WR   -> RESP
//      RESP -> IDLE on rsp_ready
//  - RD: mem_read=1 for exactly 1 cycle. WR: mem_write=1 for exactly 1 cycle.
//    mem_addr is held from RD through WR. Strobes are 0 in all other states.
//  - WAIT: take lane = addr[1:0] of mem_rdata.
//      Loads: B/BU use byte lane*8, H/HU use halfword addr[1]*16.
//        B/H sign-extend, BU/HU zero-extend.
//      SB/SH: replace that byte/halfword in mem_rdata with wdata[7:0]/[15:0]; the result is mem_wdata.
//  - RESP: rsp_valid=1; rsp_data/rsp_err held stable until rsp_ready. rsp_data=0 for stores.
//  - Latency from accept cycle to the rsp_valid cycle:
//      load 3 cycles, SW 2 cycles, SB/SH 4 cycles, error 1 cycle.
//  - Exactly one request in flight; no new accept while rsp_valid=1 and rsp_ready=0.
//  - Funct3 011/110/111: treated as error.
// STRUCTURE
//  - Shared package: funct3 encodings (F3_B..F3_HU), FSM state encoding
//    (IDLE, RD, WAIT, WR, RESP), XLEN.
//  - Sub-module byte_lane_align (combinational): inputs word, addr[1:0], funct3, wdata.
//    Outputs load_ext and store_merged. Everything else is the FSM plus request registers in the top.
// TESTING
//  - Memory: 1-cycle registered data-memory model, word[3]=0x8899AABB.
//  - Test 1, LW: LW addr=0x0C.
//    Expect mem_read pulse with mem_addr=3, then rsp_data=0x8899AABB, 3 cycles after accept.
//  - Test 2, LB/LBU: LB addr=0x0D -> rsp_data=0xFFFFFFAA. LBU addr=0x0D -> 0x000000AA.
//    LH addr=0x0E -> 0xFFFF8899.
//  - Test 3, SB RMW: SB addr=0x0E, wdata=0x12345677.
//    Expect read of word 3, then one mem_write of 0x8877AABB, then rsp_valid with rsp_data=0.
//  - Test 4, errors: LW addr=0x0E -> rsp_err=1 next cycle, no strobe.
//    SW addr=0x80 (word 32) -> rsp_err=1, no mem_write.
//  - Test 5, backpressure: hold rsp_ready=0 for 5 cycles after a LW.
//    Expect rsp_data stable, req_ready=0; accept only after rsp_ready=1.
//  - Test 6, reset in WAIT of SH: rst_n=0 for 1 cycle.
//    Expect no mem_write ever, all outputs 0, req_ready=1 next cycle.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared widths, funct3 encodings and FSM states for the load/store unit
package mem_access_ctrl_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request, data-memory and response signals of the load/store unit
//   req_*  execute-stage request (valid/ready, store, funct3, byte addr, store data)
//   mem_*  word-indexed data-memory port (read/write strobes, addr, wdata, registered rdata)
//   rsp_*  writeback response (valid/ready, extended data, error)
//   slave modport is the controller view, master modport is the surrounding pipeline/memory
interface mem_access_ctrl_if
    import mem_access_ctrl_pkg::*;
;
    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata, rsp_ready,
        input  req_ready, mem_read, mem_write, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata, rsp_ready,
        output req_ready, mem_read, mem_write, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/mem_access_ctrl_byte_lane_align.sv
// mem_access_ctrl_byte_lane_align: combinational sub-word extract/extend and read-modify-write merge
//   word         memory word read back
//   lane         byte address bits [1:0]
//   funct3       access size/sign encoding
//   wdata        store data (rs2)
//   load_ext     sign/zero-extended load result
//   store_merged word with the addressed byte/halfword replaced by wdata
module mem_access_ctrl_byte_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_ext,
    output logic [XLEN-1:0] store_merged
);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] bmask;
    always_comb begin
        b            = 8'(word >> {lane, 3'b000});
        h            = lane[1] ? word[31:16] : word[15:0];
        load_ext     = funct3 == F3_B  ? {{24{b[7]}}, b}  :
                       funct3 == F3_BU ? {24'b0, b}       :
                       funct3 == F3_H  ? {{16{h[15]}}, h} :
                       funct3 == F3_HU ? {16'b0, h}       : word;
        bmask        = 32'hFF << {lane, 3'b000};
        store_merged = funct3 == F3_B ? (word & ~bmask) | ({24'b0, wdata[7:0]} << {lane, 3'b000}) :
                       funct3 == F3_H ? (lane[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]}) :
                       wdata;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store unit turning byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW into word memory cycles
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mem_access_ctrl_if.slave: request, data-memory and writeback response channels
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_ctrl_if.slave bus
);
    state_t          state, state_d;
    logic [XLEN-1:0] addr_q, wdata_q, data_q;
    logic [2:0]      f3_q;
    logic            store_q, err_q;
    logic            f3_err, size_err, range_err, acc_err;
    logic [XLEN-1:0] load_ext, store_merged;

    mem_access_ctrl_byte_lane_align u_align (
        .word         (bus.mem_rdata),
        .lane         (addr_q[1:0]),
        .funct3       (f3_q),
        .wdata        (wdata_q),
        .load_ext     (load_ext),
        .store_merged (store_merged)
    );

    always_comb begin
        f3_err    = bus.req_store ? bus.req_funct3 > F3_W
                                  : !(bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        size_err  = ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0]) ||
                    (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00);
        range_err = {2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS);
        acc_err   = f3_err || size_err || range_err;
        // SW skips the read; sub-word stores need the old word for the merge
        state_d   = state == IDLE ? (!bus.req_valid ? IDLE :
                                     acc_err ? RESP :
                                     (bus.req_store && bus.req_funct3 == F3_W) ? WR : RD) :
                    state == RD   ? WAIT :
                    state == WAIT ? (store_q ? WR : RESP) :
                    state == WR   ? RESP :
                    bus.rsp_ready ? IDLE : RESP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && bus.req_valid) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                f3_q    <= bus.req_funct3;
                store_q <= bus.req_store;
                err_q   <= acc_err;
                data_q  <= '0;
            end
            // wdata_q becomes the merged word for sub-word stores
            if (state == WAIT) begin
                data_q  <= store_q ? '0 : load_ext;
                wdata_q <= store_merged;
            end
        end
    end

    // strobes are gated by rst_n so a reset cycle never issues a memory access
    assign bus.req_ready = state == IDLE;
    assign bus.mem_read  = rst_n && state == RD;
    assign bus.mem_write = rst_n && state == WR;
    assign bus.mem_addr  = {2'b00, addr_q[31:2]};
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed checks of mem_access_ctrl against a behavioural model
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b1;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem [32];
    logic [31:0] mem [32];
    int          n_rd = 0;
    int          n_wr = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.MEM_WORDS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
        end else begin
            if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[4:0]];
            if (bus.mem_write) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_read) begin
            n_rd <= n_rd + 1;
            last_rd_addr <= bus.mem_addr;
        end
        if (bus.mem_write) begin
            n_wr <= n_wr + 1;
            last_wr_addr <= bus.mem_addr;
            last_wr_data <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic        err;
        int          sz, lat, exp_lat, rd0, wr0, exp_rd;
        logic [63:0] m;
        logic [31:0] mask, w, v, exp_data, new_w, held;
        sz   = 1 << f3[1:0];
        m    = (64'd1 << (8 * sz)) - 64'd1;
        mask = m[31:0];
        err  = (st ? f3 > 3'd2 : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
               (a % sz) != 0 || (a / 4) >= 32;
        w        = err ? 32'h0 : ref_mem[a[6:2]];
        v        = (w >> (8 * (a % 4))) & mask;
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        new_w    = (w & ~(mask << (8 * (a % 4)))) | ((wd & mask) << (8 * (a % 4)));
        exp_data = (err || st) ? 32'h0 : v;
        exp_lat  = err ? 1 : !st ? 3 : sz == 4 ? 2 : 4;
        exp_rd   = (err || (st && sz == 4)) ? 0 : 1;
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        rd0 = n_rd;
        wr0 = n_wr;
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rsp_data"}, bus.rsp_data, exp_data);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(err));
        check({tag, "_reads"}, 32'(n_rd - rd0), 32'(exp_rd));
        check({tag, "_writes"}, 32'(n_wr - wr0), 32'((!err && st) ? 1 : 0));
        if (exp_rd == 1) check({tag, "_rd_addr"}, last_rd_addr, a / 4);
        if (!err && st) begin
            check({tag, "_wr_addr"}, last_wr_addr, a / 4);
            check({tag, "_wr_data"}, last_wr_data, new_w);
            ref_mem[a[6:2]] = new_w;
        end
        held = bus.rsp_data;
        rd0  = n_rd;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid  = 1'b1;
            bus.req_store  = 1'b0;
            bus.req_funct3 = 3'd2;
            bus.req_addr   = 32'h0;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_hold_data"}, bus.rsp_data, held);
            check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        if (hold > 0) check({tag, "_hold_no_read"}, 32'(n_rd - rd0), 32'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int rd0, wr0;
        for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
        ref_mem[3] = 32'h8899AABB;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        init  = 1'b0;
        rst_n = 1'b1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);

        run("lw", 1'b0, 3'd2, 32'h0C, 32'h0, 0);
        run("lb", 1'b0, 3'd0, 32'h0D, 32'h0, 0);
        run("lbu", 1'b0, 3'd4, 32'h0D, 32'h0, 0);
        run("lh", 1'b0, 3'd1, 32'h0E, 32'h0, 0);
        run("sb", 1'b1, 3'd0, 32'h0E, 32'h12345677, 0);
        check("sb_word3", ref_mem[3], 32'h8877AABB);
        run("lw_mis", 1'b0, 3'd2, 32'h0E, 32'h0, 0);
        run("sw_range", 1'b1, 3'd2, 32'h80, 32'hDEADBEEF, 0);
        run("bad_f3", 1'b0, 3'd3, 32'h10, 32'h0, 0);
        run("backpressure", 1'b0, 3'd2, 32'h0C, 32'h0, 5);

        rd0 = n_rd;
        wr0 = n_wr;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'd1;
        bus.req_addr   = 32'h0E;
        bus.req_wdata  = 32'hCAFE5555;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_sh_read", 32'(n_rd - rd0), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_sh_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_sh_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_sh_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_sh_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_sh_rsp_data", bus.rsp_data, 32'd0);
        check("rst_sh_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_sh_mem_addr", bus.mem_addr, 32'd0);
        check("rst_sh_mem_wdata", bus.mem_wdata, 32'd0);
        repeat (5) @(negedge clk);
        check("rst_sh_no_write", 32'(n_wr - wr0), 32'd0);

        for (int n = 0; n < 200; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
            run("rand", st, f3, a, $urandom, $urandom_range(0, 3));
        end
        run("final_lw3", 1'b0, 3'd2, 32'h0C, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
